// File: rtl/irq_ctrl_if.sv
// Request/acknowledge and end-of-interrupt handshake between irq_ctrl and the core.
// master: the interrupt controller side; slave: the core side.
interface irq_ctrl_if #(
  parameter int NUM_IRQ = 16
) ();
  localparam int ID_W = $clog2(NUM_IRQ);

  logic            req_valid;
  logic [ID_W-1:0] req_id;
  logic            req_ready;
  logic            eoi_valid;
  logic [ID_W-1:0] eoi_id;

  modport master (
    output req_valid,
    output req_id,
    input  req_ready,
    input  eoi_valid,
    input  eoi_id
  );

  modport slave (
    input  req_valid,
    input  req_id,
    output req_ready,
    output eoi_valid,
    output eoi_id
  );
endinterface

// File: rtl/irq_ctrl.sv
// Edge-triggered, non-nesting interrupt controller with fixed lowest-index priority and EOI pulse.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchronizer on every irq_in line.
//
// state   | meaning
// IDLE    | waiting for an unmasked pending line
// PRESENT | req_valid high, req_id frozen until the core accepts
// SERVICE | interrupt in service, waiting for matching eoi
// EOI     | eoi_out pulse on the in-service line for EOI_PULSE cycles
module irq_ctrl #(
  parameter int NUM_IRQ   = 16,
  parameter int EOI_PULSE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  irq_ctrl_if.master         bus,
  output logic [NUM_IRQ-1:0] eoi_out,
  output logic               busy
);
  localparam int ID_W = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {IDLE, PRESENT, SERVICE, EOI} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] line;
  logic [NUM_IRQ-1:0] prev_q, prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] eoi_out_q, eoi_out_d;
  logic [NUM_IRQ-1:0] edge_v, elig;
  logic [ID_W-1:0]    req_id_q, req_id_d;
  logic [ID_W-1:0]    svc_id_q, svc_id_d;
  logic [ID_W-1:0]    low_id;
  logic [3:0]         cnt_q, cnt_d;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync1_d;
  logic [NUM_IRQ-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign line = sync2_q;
`else
  assign line = irq_in;
`endif

  always_comb begin
    prev_d = line;
    edge_v = line & ~prev_q;
    elig   = pending_q & ~irq_mask;
    low_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) low_id = ID_W'(i);
    end

    state_d   = state_q;
    pending_d = pending_q | edge_v;
    req_id_d  = req_id_q;
    svc_id_d  = svc_id_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (|elig) begin
          req_id_d = low_id;
          state_d  = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.req_ready) begin
          // a fresh edge on the line being accepted keeps it pending
          pending_d[req_id_q] = edge_v[req_id_q];
          svc_id_d            = req_id_q;
          state_d             = SERVICE;
        end
      end
      SERVICE: begin
        if (bus.eoi_valid && (bus.eoi_id == svc_id_q)) begin
          cnt_d   = 4'(EOI_PULSE);
          state_d = EOI;
        end
      end
      EOI: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    eoi_out_d = '0;
    if (state_d == EOI) eoi_out_d[svc_id_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      eoi_out_q <= '0;
      req_id_q  <= '0;
      svc_id_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      eoi_out_q <= eoi_out_d;
      req_id_q  <= req_id_d;
      svc_id_q  <= svc_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.req_valid = (state_q == PRESENT);
  assign bus.req_id    = req_id_q;
  assign busy          = (state_q != IDLE);
  assign eoi_out       = eoi_out_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scenarios plus a randomized run against a behavioural model of irq_ctrl.
module tb_irq_ctrl;
  localparam int N  = 16;
  localparam int EP = 4;
  localparam int IW = 4;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic [N-1:0] irq_mask;
  logic [N-1:0] eoi_out;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  irq_ctrl #(.NUM_IRQ(N), .EOI_PULSE(EP)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .irq_mask (irq_mask),
    .bus      (bus.master),
    .eoi_out  (eoi_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Behavioural reference: pending set, phase of the one active interrupt, pulse cycles left.
  logic [N-1:0]  m_prev, m_s1, m_s2, m_pend, m_line, m_edges, m_elig;
  logic [IW-1:0] m_id;
  int            m_phase;   // 0 idle, 1 presenting, 2 in service, 3 eoi pulse
  int            m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_prev = '0; m_s1 = '0; m_s2 = '0; m_pend = '0;
      m_id = '0; m_phase = 0; m_left = 0;
    end else begin
`ifdef IRQ_CTRL_SYNC_EN
      m_line = m_s2;
      m_s2   = m_s1;
      m_s1   = irq_in;
`else
      m_line = irq_in;
`endif
      m_edges = m_line & ~m_prev;
      m_prev  = m_line;
      m_elig  = m_pend & ~irq_mask;
      m_pend  = m_pend | m_edges;
      case (m_phase)
        0: if (m_elig != '0) begin
             for (int i = 0; i < N; i++) if (m_elig[i]) begin m_id = IW'(i); break; end
             m_phase = 1;
           end
        1: if (bus.req_ready) begin
             m_pend[m_id] = m_edges[m_id];
             m_phase = 2;
           end
        2: if (bus.eoi_valid && bus.eoi_id == m_id) begin
             m_phase = 3;
             m_left  = EP;
           end
        default: begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!bus.req_valid && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Call in SERVICE at a negedge; returns measured pulse length and whether every pulse cycle was one-hot on id.
  task automatic do_eoi(input logic [IW-1:0] id, output int len, output logic shape_ok);
    bus.eoi_valid = 1'b1;
    bus.eoi_id    = id;
    tick();
    bus.eoi_valid = 1'b0;
    len      = 0;
    shape_ok = 1'b1;
    while (eoi_out != '0 && len < 50) begin
      if (eoi_out !== (N'(1) << id)) shape_ok = 1'b0;
      len++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (bus.req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", bus.req_valid); end
    n_tests++; if (bus.req_id !== '0) begin n_fail++; $display("FAIL reset_req_id got %0d want 0", bus.req_id); end
    n_tests++; if (eoi_out !== '0) begin n_fail++; $display("FAIL reset_eoi_out got %h want 0", eoi_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int cyc, len; logic ok;
    bus.req_ready = 1'b1;
    irq_in[5] = 1'b1;
    wait_valid(20, cyc);
    n_tests++; if (!bus.req_valid || cyc != LAT + 1) begin n_fail++; $display("FAIL single_latency got %0d edges (valid %b) want %0d", cyc, bus.req_valid, LAT + 1); end
    n_tests++; if (bus.req_id !== 4'd5) begin n_fail++; $display("FAIL single_id got %0d want 5", bus.req_id); end
    tick();
    n_tests++; if (bus.req_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_service got valid %b busy %b want 0 1", bus.req_valid, busy); end
    do_eoi(4'd5, len, ok);
    n_tests++; if (len != EP || !ok) begin n_fail++; $display("FAIL single_eoi_pulse got len %0d shape %b want len %0d on 0020", len, ok, EP); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got %b want 0", busy); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_priority();
    int cyc, len; logic ok;
    bus.req_ready = 1'b1;
    irq_in[3] = 1'b1;
    irq_in[9] = 1'b1;
    wait_valid(20, cyc);
    n_tests++; if (!bus.req_valid || bus.req_id !== 4'd3) begin n_fail++; $display("FAIL prio_first got valid %b id %0d want 1 3", bus.req_valid, bus.req_id); end
    tick();
    do_eoi(4'd3, len, ok);
    wait_valid(20, cyc);
    n_tests++; if (!bus.req_valid || bus.req_id !== 4'd9) begin n_fail++; $display("FAIL prio_second got valid %b id %0d want 1 9", bus.req_valid, bus.req_id); end
    tick();
    do_eoi(4'd9, len, ok);
    n_tests++; if (len != EP || !ok || busy !== 1'b0) begin n_fail++; $display("FAIL prio_eoi9 got len %0d shape %b busy %b", len, ok, busy); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_mask();
    int cyc, seen, len; logic ok;
    bus.req_ready = 1'b1;
    irq_mask[2] = 1'b1;
    irq_in[2] = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (bus.req_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mask_blocks got %0d valid cycles want 0", seen); end
    irq_mask[2] = 1'b0;
    wait_valid(10, cyc);
    n_tests++; if (!bus.req_valid || cyc != 1 || bus.req_id !== 4'd2) begin n_fail++; $display("FAIL mask_release got valid %b after %0d id %0d want 1 after 1 id 2", bus.req_valid, cyc, bus.req_id); end
    tick();
    do_eoi(4'd2, len, ok);
    irq_in = '0;
    tick();
  endtask

  task automatic test_hold();
    int cyc, bad, len; logic ok;
    bus.req_ready = 1'b0;
    irq_in[7] = 1'b1;
    wait_valid(20, cyc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.req_valid || bus.req_id !== 4'd7) bad++;
      if (i == 4) begin
        irq_mask[7] = 1'b1;
        irq_in[1]   = 1'b1;
      end
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
    bus.req_ready = 1'b1;
    tick();
    n_tests++; if (bus.req_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL hold_accept got valid %b busy %b want 0 1", bus.req_valid, busy); end
    do_eoi(4'd7, len, ok);
    n_tests++; if (len != EP || !ok) begin n_fail++; $display("FAIL hold_eoi7 got len %0d shape %b want %0d 1", len, ok, EP); end
    wait_valid(20, cyc);
    n_tests++; if (!bus.req_valid || bus.req_id !== 4'd1) begin n_fail++; $display("FAIL hold_next got valid %b id %0d want 1 1", bus.req_valid, bus.req_id); end
    tick();
    do_eoi(4'd1, len, ok);
    irq_mask = '0;
    irq_in   = '0;
    tick();
  endtask

  task automatic test_eoi_mismatch();
    int cyc, bad, len; logic ok;
    bus.req_ready = 1'b1;
    irq_in[4] = 1'b1;
    wait_valid(20, cyc);
    tick();
    bus.eoi_valid = 1'b1;
    bus.eoi_id    = 4'd6;
    bad = 0;
    repeat (3) begin
      tick();
      if (eoi_out !== '0 || busy !== 1'b1) bad++;
    end
    bus.eoi_valid = 1'b0;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL eoi_mismatch got %0d bad cycles want 0", bad); end
    do_eoi(4'd4, len, ok);
    n_tests++; if (len != EP || !ok) begin n_fail++; $display("FAIL eoi_match got len %0d shape %b want %0d on 0010", len, ok, EP); end
    irq_in = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc, seen;
    bus.req_ready = 1'b1;
    irq_in[1] = 1'b1;
    wait_valid(20, cyc);
    tick();
    irq_in[6] = 1'b1;
    tick();
    bus.eoi_valid = 1'b1;
    bus.eoi_id    = 4'd1;
    tick();
    bus.eoi_valid = 1'b0;
    tick();
    n_tests++; if (eoi_out !== 16'h0002) begin n_fail++; $display("FAIL rstmid_pulse got %h want 0002", eoi_out); end
    rst    = 1'b1;
    irq_in = '0;
    tick();
    n_tests++; if (eoi_out !== '0 || bus.req_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort got eoi %h valid %b busy %b want 0 0 0", eoi_out, bus.req_valid, busy); end
    tick();
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (bus.req_valid) seen++;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_pending got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_high_at_release();
    int cyc, len; logic ok;
    rst = 1'b1;
    irq_in[8] = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    wait_valid(20, cyc);
    n_tests++; if (!bus.req_valid || bus.req_id !== 4'd8) begin n_fail++; $display("FAIL release_high got valid %b id %0d want 1 8", bus.req_valid, bus.req_id); end
    tick();
    do_eoi(4'd8, len, ok);
    irq_in = '0;
    tick();
  endtask

  task automatic test_random();
    logic         exp_valid, exp_busy;
    logic [N-1:0] exp_eoi;
    int           bad = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      exp_valid = (m_phase == 1);
      exp_busy  = (m_phase != 0);
      exp_eoi   = (m_phase == 3) ? (N'(1) << m_id) : '0;
      n_tests++;
      if (bus.req_valid !== exp_valid || bus.req_id !== m_id || eoi_out !== exp_eoi || busy !== exp_busy) begin
        n_fail++;
        if (bad < 10) $display("FAIL random_cycle%0d got valid %b id %0d eoi %h busy %b want %b %0d %h %b",
                               c, bus.req_valid, bus.req_id, eoi_out, busy, exp_valid, m_id, exp_eoi, exp_busy);
        bad++;
      end
      rst           = ($urandom_range(0, 399) == 0);
      irq_in        = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) irq_mask = N'($urandom) & N'($urandom);
      bus.req_ready = 1'($urandom_range(0, 1));
      bus.eoi_valid = ($urandom_range(0, 2) == 0);
      bus.eoi_id    = $urandom_range(0, 1) ? m_id : IW'($urandom_range(0, N - 1));
    end
    rst = 1'b1;
    irq_in = '0; irq_mask = '0; bus.eoi_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    irq_in        = '0;
    irq_mask      = '0;
    bus.req_ready = 1'b0;
    bus.eoi_valid = 1'b0;
    bus.eoi_id    = '0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_hold();
    test_eoi_mismatch();
    test_reset_mid();
    test_high_at_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish in time, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 16, number of interrupt lines.
REQ-002 SHALL have parameter EOI_PULSE, default 4, eoi_out pulse width in clk cycles (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port irq_in  input  NUM_IRQ  raw interrupt lines from pad input cells; asynchronous to clk.
REQ-006 SHALL have port irq_mask  input  NUM_IRQ  1 = line masked from arbitration.
REQ-007 SHALL have port req_valid  output  1  interrupt request to core.
REQ-008 SHALL have port req_id  output  $clog2(NUM_IRQ)  index of presented interrupt.
REQ-009 SHALL have port req_ready  input  1  core accepts presented interrupt.
REQ-010 SHALL have port eoi_valid  input  1  core signals end of interrupt.
REQ-011 SHALL have port eoi_id  input  $clog2(NUM_IRQ)  index being completed.
REQ-012 SHALL have port eoi_out  output  NUM_IRQ  per-line EOI pulse to pad output cells.
REQ-013 SHALL have port busy  output  1  high in PRESENT, SERVICE, EOI states.

Function
REQ-014 SHALL detect rising edges of each irq line (current vs previous registered sample) and set pending[i] on an edge.
REQ-015 SHALL coalesce an edge on an already-pending line (pending stays 1, no count).
REQ-016 SHALL retain pending bits of masked lines; unmasking makes them eligible next cycle.
REQ-017 SHALL use FSM states IDLE, PRESENT, SERVICE, EOI.
REQ-018 IDLE: if (pending & ~irq_mask) != 0, SHALL latch lowest set index into req_id and go PRESENT next edge.
REQ-019 PRESENT: req_valid=1, req_id held stable until req_valid&&req_ready; mask/pending changes SHALL NOT alter req_id.
REQ-020 On req_valid&&req_ready SHALL clear pending[req_id], record in-service id, go SERVICE.
REQ-021 Same-cycle new edge on the line being cleared SHALL win: pending stays 1.
REQ-022 SERVICE: req_valid=0; on eoi_valid with eoi_id==in-service id SHALL go EOI; mismatched eoi_id or eoi_valid in other states SHALL be ignored.
REQ-023 EOI: eoi_out[in-service id]=1 for exactly EOI_PULSE cycles, all other bits 0, then IDLE.
REQ-024 No nesting: at most one interrupt in service; eoi_out SHALL be one-hot or zero.
REQ-025 Latency: irq_in rising sampled at edge k -> req_valid high after edge k+3 (sync in) or k+1 (sync out), when idle and unmasked.

Reset
REQ-026 While rst=1 at a clk edge: state=IDLE, pending=0, sync/previous-sample regs=0, pulse counter=0, req_valid=0, req_id=0, eoi_out=0, busy=0.
REQ-027 Reset mid-operation SHALL abort any presentation or EOI pulse; eoi_out=0 next cycle.
REQ-028 A line already high at reset release SHALL be treated as a rising edge.

Configuration
REQ-029 Macro IRQ_CTRL_SYNC_EN defined: each irq_in line SHALL pass a 2-flop synchronizer before edge detection.
REQ-030 IRQ_CTRL_SYNC_EN undefined: edge detection SHALL operate directly on irq_in (inputs already synchronous); latency per REQ-025.

Verification
REQ-031 irq_in[5] 0->1, mask=0, req_ready=1 -> req_valid high with req_id=5 after REQ-025 latency; eoi_valid,eoi_id=5 -> eoi_out=16'h0020 for 4 cycles, then busy=0.
REQ-032 irq_in[3] and [9] rise same cycle -> req_id=3 first; after EOI of 3, req_id=9 presented.
REQ-033 irq_mask[2]=1, irq_in[2] rises -> no req_valid for 20 cycles; clear mask -> req_valid with req_id=2 next eligible cycle.
REQ-034 req_ready=0 for 10 cycles with req_id=7 while irq_mask[7] set mid-wait -> req_valid, req_id=7 held stable until accepted.
REQ-035 In SERVICE of id 4, eoi_id=6 -> ignored, eoi_out stays 0; then eoi_id=4 -> pulse on bit 4.
REQ-036 rst asserted at cycle 2 of EOI pulse on bit 1 -> eoi_out=0, req_valid=0, pending=0 next cycle.
